riscv_v_operand_bypass: RTL

- Parametrised successor to the vector operand bypass stage. Sits between vector register-file read and the vector execute units.
- Forwards recently written-back vector results to vs1/vs2 through a small write-back history buffer.
- Performs SEW-aware scalar splat (vx/vi forms) on operand A.
- Presents operands through a registered valid/ready output stage.

---
 rtl/riscv_v_pkg.sv | 23 ++
 rtl/riscv_v_splat.sv | 29 ++
 rtl/riscv_v_operand_bypass.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_v_pkg.sv
// rtl/riscv_v_pkg.sv - shared vector types and defaults for the operand path
package riscv_v_pkg;

  localparam int RISCV_V_DATA_WIDTH = 128;
  localparam int HIST_DEPTH_DEFAULT = 2;
  localparam int REG_ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_t;

  typedef logic [RISCV_V_DATA_WIDTH-1:0] riscv_v_data_t;

  typedef struct packed {
    logic                          valid;
    logic [REG_ADDR_W_DEFAULT-1:0] addr;
    riscv_v_data_t                 data;
  } riscv_v_fwd_entry_t;

endpackage

// File: rtl/riscv_v_splat.sv
// rtl/riscv_v_splat.sv - SEW-aware sign-extending scalar splat across a vector
module riscv_v_splat
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
  parameter int XLEN       = 32
) (
  input  logic [XLEN-1:0]       integer_data,
  input  sew_t                  sew,
  output logic [DATA_WIDTH-1:0] splat
);

  // The low bytes of a 64-bit sign extension are exactly the truncated and
  // sign-extended element for every narrower SEW, so one source serves all.
  logic [63:0] ext;
  logic [2:0]  byte_mask;

  assign ext       = 64'(signed'(integer_data));
  assign byte_mask = 3'((4'd1 << sew) - 4'd1);

  // Each output byte copies the byte at the same offset within its element.
  always_comb begin
    splat = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      splat[i*8 +: 8] = ext[32'(3'(i) & byte_mask) * 8 +: 8];
    end
  end

endmodule

// File: rtl/riscv_v_operand_bypass.sv
// rtl/riscv_v_operand_bypass.sv - vector operand forwarding, splat and output register
module riscv_v_operand_bypass
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
  parameter int XLEN       = 32,
  parameter int HIST_DEPTH = HIST_DEPTH_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] vs1_addr,
  input  logic [REG_ADDR_W-1:0] vs2_addr,
  input  logic [DATA_WIDTH-1:0] srca,
  input  logic [DATA_WIDTH-1:0] srcb,
  input  logic                  is_scalar_int,
  input  logic [XLEN-1:0]       integer_data,
  input  logic [1:0]            sew,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] srca_byp,
  output logic [DATA_WIDTH-1:0] srcb_byp,
  output logic [1:0]            fwd_hit
);

  logic [HIST_DEPTH-1:0] hist_valid;
  logic [REG_ADDR_W-1:0] hist_addr [HIST_DEPTH];
  logic [DATA_WIDTH-1:0] hist_data [HIST_DEPTH];

  logic [DATA_WIDTH-1:0] splat_data;
  logic [DATA_WIDTH-1:0] a_data, b_data;
  logic                  a_hit, b_hit;
  logic                  capture;

  riscv_v_splat #(
    .DATA_WIDTH(DATA_WIDTH),
    .XLEN      (XLEN)
  ) u_splat (
    .integer_data(integer_data),
    .sew         (sew_t'(sew)),
    .splat       (splat_data)
  );

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  // Write-back history: shifts on every write-back regardless of stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_addr[i] <= '0;
        hist_data[i] <= '0;
      end
    end else if (flush) begin
      hist_valid <= '0;
    end else if (wb_valid) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hist_valid[i] <= hist_valid[i-1];
        hist_addr[i]  <= hist_addr[i-1];
        hist_data[i]  <= hist_data[i-1];
      end
      hist_valid[0] <= 1'b1;
      hist_addr[0]  <= wb_addr;
      hist_data[0]  <= wb_data;
    end
  end

  // Operand resolution: oldest to youngest so later matches override, then
  // the same-cycle write-back, then the scalar splat for operand A.
  always_comb begin
    a_data = srca;
    b_data = srcb;
    a_hit  = 1'b0;
    b_hit  = 1'b0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (hist_valid[i] && hist_addr[i] == vs1_addr) begin
        a_data = hist_data[i];
        a_hit  = 1'b1;
      end
      if (hist_valid[i] && hist_addr[i] == vs2_addr) begin
        b_data = hist_data[i];
        b_hit  = 1'b1;
      end
    end
    if (wb_valid && wb_addr == vs1_addr) begin
      a_data = wb_data;
      a_hit  = 1'b1;
    end
    if (wb_valid && wb_addr == vs2_addr) begin
      b_data = wb_data;
      b_hit  = 1'b1;
    end
    if (is_scalar_int) begin
      a_data = splat_data;
      a_hit  = 1'b0;
    end
  end

  // Output register: flush beats capture; outputs hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      srca_byp  <= '0;
      srcb_byp  <= '0;
      fwd_hit   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      srca_byp  <= a_data;
      srcb_byp  <= b_data;
      fwd_hit   <= {b_hit, a_hit};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
